// File: rtl/oqpsk_chip_spreader_if.sv
// oqpsk_chip_spreader_if: FIFO read handshake and chip stream bundle.
// master is the spreader side, slave the FIFO / modulator side.
interface oqpsk_chip_spreader_if;
  logic [3:0] inData;
  logic       inEmpty;
  logic       outReadEnable;
  logic       outChip;
  logic       outI;
  logic       outQ;
  logic       outValid;
  logic       outSymbolDone;
  logic       outBusy;

  modport master (
    input  inData,
    input  inEmpty,
    output outReadEnable,
    output outChip,
    output outI,
    output outQ,
    output outValid,
    output outSymbolDone,
    output outBusy
  );

  modport slave (
    output inData,
    output inEmpty,
    input  outReadEnable,
    input  outChip,
    input  outI,
    input  outQ,
    input  outValid,
    input  outSymbolDone,
    input  outBusy
  );
endinterface

// File: rtl/oqpsk_chip_spreader.sv
// oqpsk_chip_spreader: 802.15.4 2.4 GHz DSSS spreader with O-QPSK I/Q split.
// Pulls 4-bit symbols from a FIFO and streams 32 chips per symbol.
module oqpsk_chip_spreader #(
  parameter int CHIP_DIV = 4
) (
  input logic inClock,
  input logic inReset,
  oqpsk_chip_spreader_if.master bus
);
  localparam int DW = $clog2(CHIP_DIV);
  localparam logic [DW-1:0] LAST = DW'(CHIP_DIV - 1);
  localparam logic [DW-1:0] PEN = DW'(CHIP_DIV - 2);
  localparam logic [31:0] SEQ0 = 32'hD9C3522E;
  localparam logic [31:0] ODDMASK = 32'h55555555;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    TAIL
  } state_t;

  state_t state;
  logic [DW-1:0] divCnt;
  logic [4:0] chipIdx;
  logic [31:0] shreg;
  logic [3:0] nextSym;
  logic haveNext;
  logic rdDly;
  logic readEn;
  logic chip;
  logic iReg;
  logic qReg;
  logic valid;
  logic symDone;

  logic divEnd;
  logic nextAvail;
  logic [3:0] loadSym;
  logic [31:0] loadSeq;

  // c0 sits in the MSB; symbols 1-7 rotate by 4 chips, 8-15 flip odd chips
  function automatic logic [31:0] chipSeq(input logic [3:0] s);
    logic [5:0] sh;
    logic [31:0] r;
    sh = {1'b0, s[2:0], 2'b00};
    r = (SEQ0 >> sh) | (SEQ0 << (6'd32 - sh));
    return s[3] ? (r ^ ODDMASK) : r;
  endfunction

  always_comb begin
    divEnd = (divCnt == LAST);
    nextAvail = haveNext | rdDly;
    loadSym = haveNext ? nextSym : bus.inData;
    loadSeq = chipSeq(loadSym);
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state <= IDLE;
      divCnt <= '0;
      chipIdx <= '0;
      shreg <= '0;
      nextSym <= '0;
      haveNext <= 1'b0;
      rdDly <= 1'b0;
      readEn <= 1'b0;
      chip <= 1'b0;
      iReg <= 1'b0;
      qReg <= 1'b0;
      valid <= 1'b0;
      symDone <= 1'b0;
    end else begin
      readEn <= 1'b0;
      symDone <= 1'b0;
      rdDly <= readEn;
      unique case (state)
        IDLE: begin
          if (!bus.inEmpty) begin
            state <= FETCH;
            readEn <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state <= SEND;
          divCnt <= '0;
          chipIdx <= '0;
          chip <= loadSeq[31];
          iReg <= loadSeq[31];
          shreg <= {loadSeq[30:0], 1'b0};
          valid <= 1'b1;
        end
        SEND: begin
          if (rdDly) begin
            nextSym <= bus.inData;
            haveNext <= 1'b1;
          end
          if (chipIdx == 5'd31 && divCnt == PEN) symDone <= 1'b1;
          if (!divEnd) begin
            divCnt <= divCnt + DW'(1);
          end else begin
            divCnt <= '0;
            if (chipIdx != 5'd31) begin
              chipIdx <= chipIdx + 5'd1;
              chip <= shreg[31];
              shreg <= {shreg[30:0], 1'b0};
              if (chipIdx[0]) iReg <= shreg[31];
              else qReg <= shreg[31];
              if (chipIdx == 5'd30 && !bus.inEmpty) readEn <= 1'b1;
            end else if (nextAvail) begin
              // prefetched symbol: restart at chip 0 with no gap
              chipIdx <= '0;
              chip <= loadSeq[31];
              iReg <= loadSeq[31];
              shreg <= {loadSeq[30:0], 1'b0};
              haveNext <= 1'b0;
            end else begin
              state <= TAIL;
              chip <= 1'b0;
              iReg <= 1'b0;
              shreg <= '0;
            end
          end
        end
        TAIL: begin
          if (!divEnd) begin
            divCnt <= divCnt + DW'(1);
          end else begin
            state <= IDLE;
            divCnt <= '0;
            chipIdx <= '0;
            qReg <= 1'b0;
            valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.outReadEnable = readEn;
  assign bus.outChip = chip;
  assign bus.outI = iReg;
  assign bus.outQ = qReg;
  assign bus.outValid = valid;
  assign bus.outSymbolDone = symDone;
  assign bus.outBusy = (state != IDLE);
endmodule
